spike_event_logger: RTL and testbench
=====================================

SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

Interface
REQ-001 SHALL have parameter TS_WIDTH, default 12: timestamp width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, a power of two, at least 2.
REQ-003 SHALL have parameter WINDOW, default 256: rate-window length in enabled cycles, at least 2.
REQ-004 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: gates the timestamp, the window and event capture.
REQ-007 SHALL have port spike_in, input, 1: spike flag from the upstream LIF neuron.
REQ-008 SHALL have port ev_ready, input, 1: consumer ready for the event stream.
REQ-009 SHALL have port ev_valid, output, 1: head-of-FIFO event present.
REQ-010 SHALL have port ev_data, output, TS_WIDTH: timestamp of the head event.
REQ-011 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-012 SHALL have port ev_overflow, output, 1: sticky flag, set when an event has been dropped.
REQ-013 SHALL have port rate_count, output, 8: spike-event count of the last completed window.
REQ-014 SHALL have port rate_valid, output, 1: one-cycle pulse when rate_count updates.

Function
REQ-015 SHALL register spike_in every cycle and define an event as spike_in=1 with the previous sample 0 while enable=1 (rising edge); a held-high spike_in SHALL produce exactly one event.
REQ-016 SHALL keep a free-running TS_WIDTH timestamp counter that increments on each enable=1 cycle and wraps from all-ones to 0; enable=0 SHALL freeze it.
REQ-017 SHALL push the timestamp value of the event's cycle into the FIFO; ev_valid SHALL rise the cycle after an event into an empty FIFO, one cycle of latency.
REQ-018 SHALL pop the FIFO when ev_valid and ev_ready are both 1; ev_data SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-019 SHALL, on an event with the FIFO full and no pop, drop the event, leave the contents unchanged and set ev_overflow.
REQ-020 SHALL, on an event with the FIFO full and a pop in the same cycle, complete both operations; the level stays FIFO_DEPTH and no overflow is flagged.
REQ-021 SHALL, on an event with the FIFO empty and ev_ready=1, push only, with no bypass; the event is presented next cycle.
REQ-022 SHALL let the FIFO pop with enable=0, and SHALL ignore spike_in edges while enable=0.
REQ-023 SHALL clear ev_overflow only on reset.
REQ-024 SHALL count enabled cycles modulo WINDOW and count events per window, saturating at 255.
REQ-025 SHALL, on the last enabled cycle of a window, load rate_count with the window count including any event in that cycle, pulse rate_valid high for one cycle and restart the count at 0.
REQ-026 SHALL freeze the window cycle and event counters while enable=0; rate_valid SHALL be 0 on cycles with enable=0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear the following: timestamp, window counters, FIFO pointers, fifo_level, ev_valid, ev_data, ev_overflow, rate_count, rate_valid and the spike_in history register.
REQ-028 SHALL discard FIFO contents on a reset asserted mid-operation; rst SHALL override enable, spike_in and ev_ready.
REQ-029 SHALL treat spike_in held high at reset release as a new event on the first enabled cycle, because the history register is cleared to 0.

Verification
REQ-030 SHALL cover: reset, then enable=1, spike_in pulsed high for 1 cycle when timestamp=5 -> ev_valid=1 the next cycle with ev_data=5, fifo_level=1; ev_ready=1 -> ev_valid=0 the cycle after.
REQ-031 SHALL cover: spike_in held high for 10 cycles -> exactly one event, fifo_level=1.
REQ-032 SHALL cover: ev_ready=0 and 5 separate spikes -> fifo_level=4, 5th dropped, ev_overflow=1, ev_data equals the 1st timestamp.
REQ-033 SHALL cover: FIFO full, then a spike and ev_ready=1 in the same cycle -> level stays 4, ev_overflow stays 0, the new timestamp is at the tail.
REQ-034 SHALL cover: WINDOW=256 with a spike every 4th cycle -> rate_valid pulses at enabled cycle 256 with rate_count=64; enable=0 for 20 cycles mid-window delays the pulse by exactly 20 cycles.
REQ-035 SHALL cover: timestamp at 4095 with a spike -> ev_data=4095; the next spike 3 cycles later -> ev_data=2 (wrap); rst mid-stream -> fifo_level=0, ev_valid=0, ev_overflow=0 the next cycle.

Source files
------------

// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - timestamps LIF spike edges into an event FIFO and reports per-window spike rate
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   enable       gates the timestamp, the rate window and event capture (FIFO pops still allowed)
//   spike_in     spike flag from the upstream neuron; a 0->1 transition is one event
//   ev_ready     consumer ready for the event stream
//   ev_valid     head-of-FIFO event present
//   ev_data      timestamp of the head event (0 when the FIFO is empty)
//   fifo_level   current FIFO occupancy, 0..FIFO_DEPTH
//   ev_overflow  sticky: an event was dropped because the FIFO was full
//   rate_count   spike count of the last completed window, saturating at 255
//   rate_valid   high on the last enabled cycle of each window; rate_count carries the new value then

module spike_event_logger #(
    parameter int TS_WIDTH   = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int WINDOW     = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          spike_in,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [TS_WIDTH-1:0]           ev_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ev_overflow,
    output logic [7:0]                    rate_count,
    output logic                          rate_valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(WINDOW);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);

    // spike history, timestamp
    logic                spike_q;
    logic [TS_WIDTH-1:0] ts;

    // event FIFO
    logic [TS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic                overflow_q;

    // rate window
    logic [WW-1:0]       win_cyc;
    logic [7:0]          win_ev;
    logic [7:0]          rate_q;

    // per-cycle decisions
    logic                spike_event;
    logic                fifo_empty;
    logic                fifo_full;
    logic                do_pop;
    logic                do_push;
    logic                do_drop;
    logic                win_last;
    logic [7:0]          win_ev_next;

    always_comb begin
        spike_event = enable & spike_in & ~spike_q;
        fifo_empty  = (level == '0);
        fifo_full   = (level == FULL_LEVEL);
        do_pop      = ~fifo_empty & ev_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        do_push     = spike_event & (~fifo_full | do_pop);
        do_drop     = spike_event & fifo_full & ~do_pop;
        win_last    = enable & (win_cyc == WIN_LAST);
        win_ev_next = (win_ev == 8'hFF) ? 8'hFF : (win_ev + {7'd0, spike_event});
    end

    // History register samples every cycle, so an edge seen while disabled is consumed
    // and does not turn into an event once enable returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q <= 1'b0;
            ts      <= '0;
        end else begin
            spike_q <= spike_in;
            if (enable) begin
                ts <= ts + TS_WIDTH'(1);
            end
        end
    end

    // Storage has no reset; ev_data is masked while empty so stale entries never show.
    // On full+pop+push wr_ptr equals rd_ptr: the head is read combinationally before
    // this write lands, and the new entry becomes the tail.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Window counters advance only on enabled cycles; the closing cycle's own event is
    // folded into the reported count.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cyc <= '0;
            win_ev  <= '0;
            rate_q  <= '0;
        end else if (enable) begin
            if (win_last) begin
                rate_q  <= win_ev_next;
                win_cyc <= '0;
                win_ev  <= '0;
            end else begin
                win_cyc <= win_cyc + WW'(1);
                win_ev  <= win_ev_next;
            end
        end
    end

    always_comb begin
        ev_valid    = ~fifo_empty;
        ev_data     = fifo_empty ? '0 : mem[rd_ptr];
        fifo_level  = level;
        ev_overflow = overflow_q;
        // Pulse on the closing enabled cycle itself so it can never appear while enable=0;
        // rate_count shows the value being loaded during that pulse and holds it afterwards.
        rate_valid  = win_last & ~rst;
        rate_count  = rate_valid ? win_ev_next : rate_q;
    end

endmodule

// File: tb/tb_spike_event_logger.sv
// tb/tb_spike_event_logger.sv - randomized and directed bench for spike_event_logger against a queue-based model

module tb_spike_event_logger;

    localparam int TS_WIDTH   = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int WINDOW     = 256;
    localparam int TS_MOD     = 1 << TS_WIDTH;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        enable = 1'b0;
    logic                        spike_in = 1'b0;
    logic                        ev_ready = 1'b0;
    logic                        ev_valid;
    logic [TS_WIDTH-1:0]         ev_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        ev_overflow;
    logic [7:0]                  rate_count;
    logic                        rate_valid;

    spike_event_logger #(
        .TS_WIDTH  (TS_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .WINDOW    (WINDOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .fifo_level (fifo_level),
        .ev_overflow(ev_overflow),
        .rate_count (rate_count),
        .rate_valid (rate_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: timestamps, event queue, window tallies
    int   m_ts = 0;
    bit   m_prev = 1'b0;
    int   m_q[$];
    bit   m_ovf = 1'b0;
    int   m_wcyc = 0;
    int   m_wev = 0;
    int   m_rate = 0;

    logic       s_rv;
    logic [7:0] s_rc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ts   = 0;
        m_prev = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_wcyc = 0;
        m_wev  = 0;
        m_rate = 0;
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model, cross the rising edge.
    task automatic cycle(input bit r, input bit en, input bit sp, input bit rdy);
        bit ev;
        bit exp_rv;
        int exp_rc;
        int exp_data;
        rst      = r;
        enable   = en;
        spike_in = sp;
        ev_ready = rdy;
        @(negedge clk);
        ev       = !r && en && sp && !m_prev;
        exp_rv   = !r && en && (m_wcyc == WINDOW - 1);
        exp_rc   = exp_rv ? (((m_wev + int'(ev)) > 255) ? 255 : (m_wev + int'(ev))) : m_rate;
        exp_data = (m_q.size() > 0) ? m_q[0] : 0;
        check_eq("ev_valid",    32'(ev_valid),    32'(m_q.size() > 0));
        check_eq("ev_data",     32'(ev_data),     32'(exp_data));
        check_eq("fifo_level",  32'(fifo_level),  32'(m_q.size()));
        check_eq("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        check_eq("rate_valid",  32'(rate_valid),  32'(exp_rv));
        check_eq("rate_count",  32'(rate_count),  32'(exp_rc));
        s_rv = rate_valid;
        s_rc = rate_count;
        if (r) begin
            model_reset();
        end else begin
            if (m_q.size() > 0 && rdy) begin
                void'(m_q.pop_front());
            end
            if (ev) begin
                if (m_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
                else                          m_q.push_back(m_ts);
            end
            m_prev = sp;
            if (en) begin
                m_ts  = (m_ts + 1) % TS_MOD;
                m_wev = (m_wev + int'(ev) > 255) ? 255 : m_wev + int'(ev);
                if (m_wcyc == WINDOW - 1) begin
                    m_rate = m_wev;
                    m_wcyc = 0;
                    m_wev  = 0;
                end else begin
                    m_wcyc++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_ts;
        int tail_ts;
        int idx;
        int k;
        int rc;
        bit en;
        bit sp;

        @(posedge clk);
        #1;
        repeat (3) cycle(1, 0, 0, 0);
        check_eq("reset_level", 32'(fifo_level), 32'd0);
        check_eq("reset_valid", 32'(ev_valid), 32'd0);
        check_eq("reset_ovf",   32'(ev_overflow), 32'd0);
        check_eq("reset_rate",  32'(rate_count), 32'd0);

        // single pulse at timestamp 5, then pop
        repeat (5) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        check_eq("pulse_valid", 32'(ev_valid), 32'd1);
        check_eq("pulse_data",  32'(ev_data), 32'd5);
        check_eq("pulse_level", 32'(fifo_level), 32'd1);
        cycle(0, 1, 0, 1);
        check_eq("pulse_popped", 32'(ev_valid), 32'd0);

        // held-high spike gives one event
        repeat (10) cycle(0, 1, 1, 0);
        check_eq("held_level", 32'(fifo_level), 32'd1);
        cycle(0, 1, 0, 1);
        cycle(0, 1, 0, 0);

        // five spikes with no consumer: fifth dropped
        first_ts = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) first_ts = m_ts;
            cycle(0, 1, 1, 0);
            cycle(0, 1, 0, 0);
        end
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_flag",  32'(ev_overflow), 32'd1);
        check_eq("ovf_head",  32'(ev_data), 32'(first_ts));

        // full FIFO with simultaneous push and pop
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 0);
            cycle(0, 1, 0, 0);
        end
        tail_ts = m_ts;
        cycle(0, 1, 1, 1);
        check_eq("fullpp_level", 32'(fifo_level), 32'd4);
        check_eq("fullpp_ovf",   32'(ev_overflow), 32'd0);
        repeat (3) cycle(0, 0, 0, 1);
        check_eq("fullpp_tail",  32'(ev_data), 32'(tail_ts));
        check_eq("fullpp_last",  32'(fifo_level), 32'd1);
        cycle(0, 0, 0, 1);

        // spike held high across reset release is an event
        cycle(1, 1, 1, 0);
        cycle(0, 1, 1, 0);
        check_eq("rel_level", 32'(fifo_level), 32'd1);
        cycle(0, 1, 0, 1);

        // rate window: spike every 4th enabled cycle
        cycle(1, 0, 0, 0);
        idx = -1;
        rc  = -1;
        for (int c = 0; c < WINDOW; c++) begin
            cycle(0, 1, (c % 4) == 0, 1);
            if (s_rv && idx < 0) begin
                idx = c;
                rc  = int'(s_rc);
            end
        end
        check_eq("win_index", 32'(idx), 32'(WINDOW - 1));
        check_eq("win_count", 32'(rc), 32'd64);

        // same window with a 20-cycle enable gap
        idx = -1;
        rc  = -1;
        k   = 0;
        for (int c = 0; c < WINDOW + 20; c++) begin
            en = !(c >= 100 && c < 120);
            sp = en && ((k % 4) == 0);
            cycle(0, en, sp, 1);
            if (s_rv && idx < 0) begin
                idx = c;
                rc  = int'(s_rc);
            end
            if (en) k++;
        end
        check_eq("gap_index", 32'(idx), 32'(WINDOW - 1 + 20));
        check_eq("gap_count", 32'(rc), 32'd64);

        // timestamp wrap, then mid-stream reset
        cycle(1, 0, 0, 0);
        repeat (TS_MOD - 1) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        check_eq("wrap_max", 32'(ev_data), 32'(TS_MOD - 1));
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        check_eq("wrap_level", 32'(fifo_level), 32'd2);
        cycle(0, 1, 0, 1);
        check_eq("wrap_data", 32'(ev_data), 32'd2);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 0);
            cycle(0, 1, 0, 0);
        end
        check_eq("wrap_ovf", 32'(ev_overflow), 32'd1);
        cycle(1, 1, 1, 1);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_valid", 32'(ev_valid), 32'd0);
        check_eq("rst_ovf",   32'(ev_overflow), 32'd0);

        // randomized traffic with phases of scarce and plentiful ready
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit rdy;
            r   = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) < 8);
            sp  = ($urandom_range(0, 2) == 0);
            rdy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(r, en, sp, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
